// File: rtl/seq_chk_pkg.sv
// rtl/seq_chk_pkg.sv - shared states, constants and successor function for seq_chk
package seq_chk_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [2:0] SEQ_SEED    = 3'b001;
  localparam logic [2:0] SEQ_ILLEGAL = 3'b100;

  // 100 has no successor; mapping it to the seed keeps the function total
  function automatic logic [2:0] nxt(input logic [2:0] x);
    case (x)
      3'b001:  nxt = 3'b010;
      3'b010:  nxt = 3'b011;
      3'b011:  nxt = 3'b000;
      3'b000:  nxt = 3'b111;
      3'b111:  nxt = 3'b110;
      3'b110:  nxt = 3'b101;
      3'b101:  nxt = 3'b001;
      default: nxt = SEQ_SEED;
    endcase
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// rtl/sat_cnt.sv - saturating counter; clear and increment together yield 1
module sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] base;

  always_comb begin
    base  = clr ? '0 : cnt_q;
    cnt_d = base;
    if (inc && (base != '1)) begin
      cnt_d = base + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_chk.sv
// rtl/seq_chk.sv - lock/verify checker for the 3-bit custom counter sequence
// SEQ_CHK_STATS_EN builds the err_cnt counter; otherwise err_cnt is tied to 0.
module seq_chk
  import seq_chk_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int MISS_MAX = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [2:0]       data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [2:0]       expected,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(MISS_MAX + 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] MISS_LIM  = MISS_W'(MISS_MAX);

  state_e            state_q, state_d;
  logic [2:0]        expected_q, expected_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              err_q, err_d;

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    good_d     = good_q;
    miss_d     = miss_q;
    err_d      = 1'b0;
    if (valid) begin
      case (state_q)
        HUNT: begin
          if (data != SEQ_ILLEGAL) begin
            state_d    = VERIFY;
            expected_d = nxt(data);
            good_d     = GOOD_W'(1);
          end
        end
        VERIFY: begin
          if (data == expected_q) begin
            good_d     = good_q + 1'b1;
            expected_d = nxt(data);
            if (good_d == GOOD_LOCK) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (data != SEQ_ILLEGAL) begin
            good_d     = GOOD_W'(1);
            expected_d = nxt(data);
          end else begin
            state_d = HUNT;
            good_d  = '0;
          end
        end
        LOCKED: begin
          if (data == expected_q) begin
            expected_d = nxt(data);
            miss_d     = '0;
          end else begin
            // flywheel: keep predicting from our own count, not the bad sample
            err_d      = 1'b1;
            miss_d     = miss_q + 1'b1;
            expected_d = nxt(expected_q);
            if (miss_d == MISS_LIM) begin
              state_d = HUNT;
              good_d  = '0;
              miss_d  = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      expected_q <= SEQ_SEED;
      good_q     <= '0;
      miss_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      good_q     <= good_d;
      miss_q     <= miss_d;
      err_q      <= err_d;
    end
  end

  assign locked   = (state_q == LOCKED);
  assign err      = err_q;
  assign expected = expected_q;

`ifdef SEQ_CHK_STATS_EN
  sat_cnt #(
    .WIDTH(CNT_W)
  ) u_err_cnt (
    .clk(clk),
    .rst(reset),
    .clr(clr_cnt),
    .inc(err_d),
    .cnt(err_cnt)
  );
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign err_cnt        = '0;
`endif

endmodule
